ccb_bus_tx: RTL and testbench

- Transmit side of the CCB backplane interface; drives the CCB command/data bus, strobes, BX0, BXRST, L1ARST, L1ACC and CCBCAL lines consumed by the DMB control FPGA's CCB decoder and trigger logic.
- Used as the CCB emulator in system simulation and as the bus driver in the bench/crate test firmware.
- Queues host-issued commands and data words, serialises them with fixed setup/strobe/hold timing, maintains the LHC orbit (BX) counter and the L1A event counter.

---
 rtl/ccb_bus_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_ccb_bus_tx.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccb_bus_tx.sv
// rtl/ccb_bus_tx.sv - CCB backplane transmit side: command/data serialiser, orbit and L1A counters
module ccb_bus_tx #(
    parameter int TMR       = 0,
    parameter int ORBIT_LEN = 3564,
    parameter int FIFO_AW   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        CMD_WE,
    input  logic        CMD_IS_DATA,
    input  logic [7:0]  CMD_WORD,
    output logic        CMD_FULL,
    output logic        OVERFLOW,
    input  logic        L1A_REQ,
    input  logic        L1ARST_REQ,
    input  logic        BXRST_REQ,
    input  logic [2:0]  CAL_REQ,
    output logic [5:0]  CCBCMD,
    output logic        CCBCMDSTRB,
    output logic [7:0]  CCBDATA,
    output logic        CCBDATASTRB,
    output logic        BX0,
    output logic        BXRST,
    output logic        L1ARST,
    output logic        L1ACC,
    output logic [2:0]  CCBCAL,
    output logic [11:0] BXN,
    output logic [23:0] L1ANUM
);
    typedef enum logic [1:0] {IDLE, SETUP, STRB, HOLD} state_t;

    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [11:0]        BX_LAST  = 12'(ORBIT_LEN - 1);

    logic [8:0]         fifo_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               full_q, full_d, ovf_q, ovf_d;
    logic               push, pop;
    logic [8:0]         head;

    logic [1:0]  state_q [3];
    state_t      state_d, state_v;
    logic        is_data_q, is_data_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [7:0]  data_q, data_d;
    logic        cstb_q, cstb_d, dstb_q, dstb_d;

    logic        run_q, run_d;
    logic [11:0] bxn_q [3];
    logic [11:0] bxn_d, bxn_v;
    logic        bx0_q, bx0_d, bxrst_q, bxrst_d;
    logic [23:0] l1anum_q [3];
    logic [23:0] l1anum_d, l1anum_v;
    logic        l1acc_q, l1acc_d, l1arst_q, l1arst_d;
    logic [2:0]  cal_prev_q, cal_prev_d, cal_q, cal_d;
    logic [1:0]  cal_cnt_q [3];
    logic [1:0]  cal_cnt_d [3];

    // Majority voters; with TMR off only copy 0 carries state
    always_comb begin
        if (TMR != 0) begin
            state_v  = state_t'((state_q[0] & state_q[1]) | (state_q[0] & state_q[2]) | (state_q[1] & state_q[2]));
            bxn_v    = (bxn_q[0] & bxn_q[1]) | (bxn_q[0] & bxn_q[2]) | (bxn_q[1] & bxn_q[2]);
            l1anum_v = (l1anum_q[0] & l1anum_q[1]) | (l1anum_q[0] & l1anum_q[2]) | (l1anum_q[1] & l1anum_q[2]);
        end else begin
            state_v  = state_t'(state_q[0]);
            bxn_v    = bxn_q[0];
            l1anum_v = l1anum_q[0];
        end
    end

    always_comb begin
        head     = fifo_q[rd_ptr_q];
        push     = CMD_WE && !full_q;
        pop      = (count_q != '0) && (state_v == IDLE || state_v == HOLD);
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + CNT_ONE;
        else if (pop && !push)
            count_d = count_q - CNT_ONE;
        full_d = (count_d == FULL_CNT);
        ovf_d  = ovf_q || (CMD_WE && full_q);

        state_d   = state_v;
        is_data_d = is_data_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        cstb_d    = 1'b0;
        dstb_d    = 1'b0;
        case (state_v)
            SETUP: begin
                state_d = STRB;
                cstb_d  = !is_data_q;
                dstb_d  = is_data_q;
            end
            STRB: state_d = HOLD;
            default: begin
                // IDLE and HOLD both launch the next queued entry without a gap
                if (pop) begin
                    state_d   = SETUP;
                    is_data_d = head[8];
                    cmd_d     = head[8] ? 6'h00 : head[5:0];
                    data_d    = head[8] ? head[7:0] : 8'h00;
                end else begin
                    state_d = IDLE;
                    cmd_d   = 6'h00;
                    data_d  = 8'h00;
                end
            end
        endcase
    end

    always_comb begin
        run_d = ENABLE;
        if (BXRST_REQ)
            bxn_d = 12'd0;
        else if (run_q)
            bxn_d = (bxn_v == BX_LAST) ? 12'd0 : bxn_v + 12'd1;
        else
            bxn_d = bxn_v;
        bx0_d    = run_d && (bxn_d == 12'd0);
        bxrst_d  = BXRST_REQ;
        l1acc_d  = L1A_REQ;
        l1arst_d = L1ARST_REQ;
        if (L1ARST_REQ)
            l1anum_d = 24'd0;
        else if (L1A_REQ)
            l1anum_d = l1anum_v + 24'd1;
        else
            l1anum_d = l1anum_v;

        cal_prev_d = CAL_REQ;
        cal_d      = 3'b111;
        for (int i = 0; i < 3; i++) begin
            if (CAL_REQ[i] && !cal_prev_q[i] && cal_cnt_q[i] == 2'd0)
                cal_cnt_d[i] = 2'd2;
            else if (cal_cnt_q[i] != 2'd0)
                cal_cnt_d[i] = cal_cnt_q[i] - 2'd1;
            else
                cal_cnt_d[i] = 2'd0;
            cal_d[i] = (cal_cnt_d[i] == 2'd0);
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            fifo_q[wr_ptr_q] <= {CMD_IS_DATA, CMD_WORD};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            is_data_q  <= 1'b0;
            cmd_q      <= 6'h00;
            data_q     <= 8'h00;
            cstb_q     <= 1'b0;
            dstb_q     <= 1'b0;
            run_q      <= 1'b0;
            bx0_q      <= 1'b0;
            bxrst_q    <= 1'b0;
            l1acc_q    <= 1'b0;
            l1arst_q   <= 1'b0;
            cal_prev_q <= 3'b000;
            cal_q      <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                state_q[i]   <= IDLE;
                bxn_q[i]     <= 12'd0;
                l1anum_q[i]  <= 24'd0;
                cal_cnt_q[i] <= 2'd0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            is_data_q  <= is_data_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            cstb_q     <= cstb_d;
            dstb_q     <= dstb_d;
            run_q      <= run_d;
            bx0_q      <= bx0_d;
            bxrst_q    <= bxrst_d;
            l1acc_q    <= l1acc_d;
            l1arst_q   <= l1arst_d;
            cal_prev_q <= cal_prev_d;
            cal_q      <= cal_d;
            for (int i = 0; i < 3; i++) begin
                state_q[i]   <= state_d;
                bxn_q[i]     <= bxn_d;
                l1anum_q[i]  <= l1anum_d;
                cal_cnt_q[i] <= cal_cnt_d[i];
            end
        end
    end

    assign CMD_FULL    = full_q;
    assign OVERFLOW    = ovf_q;
    assign CCBCMD      = cmd_q;
    assign CCBCMDSTRB  = cstb_q;
    assign CCBDATA     = data_q;
    assign CCBDATASTRB = dstb_q;
    assign BX0         = bx0_q;
    assign BXRST       = bxrst_q;
    assign L1ARST      = l1arst_q;
    assign L1ACC       = l1acc_q;
    assign CCBCAL      = cal_q;
    assign BXN         = bxn_v;
    assign L1ANUM      = l1anum_v;
endmodule

// File: tb/tb_ccb_bus_tx.sv
// tb/tb_ccb_bus_tx.sv - randomized self-checking bench for ccb_bus_tx against a behavioural model
module tb_ccb_bus_tx;
    localparam int ORBIT = 3564;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0, RST = 1'b1, ENABLE = 1'b0, CMD_WE = 1'b0, CMD_IS_DATA = 1'b0;
    logic [7:0]  CMD_WORD = 8'h00;
    logic        L1A_REQ = 1'b0, L1ARST_REQ = 1'b0, BXRST_REQ = 1'b0;
    logic [2:0]  CAL_REQ = 3'b000;
    logic        CMD_FULL, OVERFLOW, CCBCMDSTRB, CCBDATASTRB, BX0, BXRST, L1ARST, L1ACC;
    logic [5:0]  CCBCMD;
    logic [7:0]  CCBDATA;
    logic [2:0]  CCBCAL;
    logic [11:0] BXN;
    logic [23:0] L1ANUM;

    int n_tests = 0, n_fail = 0;

    ccb_bus_tx #(.TMR(0), .ORBIT_LEN(ORBIT), .FIFO_AW(2)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .CMD_WE(CMD_WE), .CMD_IS_DATA(CMD_IS_DATA),
        .CMD_WORD(CMD_WORD), .CMD_FULL(CMD_FULL), .OVERFLOW(OVERFLOW), .L1A_REQ(L1A_REQ),
        .L1ARST_REQ(L1ARST_REQ), .BXRST_REQ(BXRST_REQ), .CAL_REQ(CAL_REQ), .CCBCMD(CCBCMD),
        .CCBCMDSTRB(CCBCMDSTRB), .CCBDATA(CCBDATA), .CCBDATASTRB(CCBDATASTRB), .BX0(BX0),
        .BXRST(BXRST), .L1ARST(L1ARST), .L1ACC(L1ACC), .CCBCAL(CCBCAL), .BXN(BXN), .L1ANUM(L1ANUM)
    );

    always #5 CLK = ~CLK;

    // Model: an entry popped in cycle p is on its bus during p+1..p+3 and strobed at p+2;
    // another pop may follow no earlier than p+3.
    int          cyc = 0;
    logic [8:0]  mq[$];
    logic [8:0]  cur = 9'h0;
    int          last_pop = -100;
    bit          m_ovf = 0, m_run = 0;
    int          m_bxn = 0;
    logic [23:0] m_l1a = 24'd0;
    logic [2:0]  m_cal_prev = 3'b000;
    int          low_until [3] = '{-100, -100, -100};
    bit          e_bx0 = 0, e_bxrst = 0, e_l1acc = 0, e_l1arst = 0, e_cstb = 0, e_dstb = 0, e_full = 0;
    logic [5:0]  e_cmd = 6'h0;
    logic [7:0]  e_data = 8'h0;
    logic [2:0]  e_cal = 3'b111;

    task automatic model_step();
        int a;
        bit full_now;
        if (RST) begin
            mq.delete();
            last_pop = -100; m_ovf = 0; m_run = 0; m_bxn = 0; m_l1a = 24'd0;
            e_bx0 = 0; e_bxrst = 0; e_l1acc = 0; e_l1arst = 0; m_cal_prev = 3'b000;
            for (int i = 0; i < 3; i++) low_until[i] = -100;
        end else begin
            full_now = (mq.size() == DEPTH);
            if (mq.size() > 0 && cyc - last_pop >= 3) begin
                cur = mq.pop_front();
                last_pop = cyc;
            end
            if (CMD_WE) begin
                if (full_now) m_ovf = 1;
                else mq.push_back({CMD_IS_DATA, CMD_WORD});
            end
            if (BXRST_REQ) m_bxn = 0;
            else if (m_run) m_bxn = (m_bxn + 1) % ORBIT;
            m_run = ENABLE;
            e_bx0 = (m_bxn == 0) && m_run;
            e_bxrst = BXRST_REQ;
            e_l1acc = L1A_REQ;
            e_l1arst = L1ARST_REQ;
            if (L1ARST_REQ) m_l1a = 24'd0;
            else if (L1A_REQ) m_l1a = m_l1a + 24'd1;
            for (int i = 0; i < 3; i++)
                if (CAL_REQ[i] && !m_cal_prev[i] && cyc > low_until[i]) low_until[i] = cyc + 2;
            m_cal_prev = CAL_REQ;
        end
        cyc++;
        a = cyc - last_pop;
        e_cmd  = (a >= 1 && a <= 3 && !cur[8]) ? cur[5:0] : 6'h0;
        e_data = (a >= 1 && a <= 3 && cur[8]) ? cur[7:0] : 8'h0;
        e_cstb = (a == 2) && !cur[8];
        e_dstb = (a == 2) && cur[8];
        e_full = (mq.size() == DEPTH);
        for (int i = 0; i < 3; i++) e_cal[i] = !(cyc <= low_until[i]);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; tick(); tick(); RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if ({CCBCMD, CCBCMDSTRB, CCBDATA, CCBDATASTRB, BX0, BXRST, L1ARST, L1ACC, CCBCAL, BXN, L1ANUM, CMD_FULL, OVERFLOW}
                !== {6'h0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 12'h0, 24'h0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d cmd=%h data=%h cal=%b bxn=%0d l1a=%0d full=%b ovf=%b (required all zero, cal=111)",
                         i, CCBCMD, CCBDATA, CCBCAL, BXN, L1ANUM, CMD_FULL, OVERFLOW);
            end
        end
        CMD_WE = 1'b1; CMD_IS_DATA = 1'b0; CMD_WORD = 8'h15; tick(); CMD_WE = 1'b0;
        tick();
        n_tests++;
        if (CCBCMD !== 6'h15 || CCBCMD !== e_cmd) begin
            n_fail++; $display("FAIL abort_setup got=%h required=%h", CCBCMD, 6'h15);
        end
        RST = 1'b1; tick(); RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if ({CCBCMD, CCBCMDSTRB, CCBDATASTRB} !== 8'h00) begin
                n_fail++; $display("FAIL abort_no_strobe cyc=%0d cmd=%h cstb=%b dstb=%b required 0", i, CCBCMD, CCBCMDSTRB, CCBDATASTRB);
            end
        end
    endtask

    task automatic test_cmd_data();
        int t_c = -1, t_d = -1;
        CMD_WE = 1'b1; CMD_IS_DATA = 1'b0; CMD_WORD = 8'h2A; tick();
        CMD_IS_DATA = 1'b1; CMD_WORD = 8'hC3; tick();
        CMD_WE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if ({CCBCMD, CCBCMDSTRB, CCBDATA, CCBDATASTRB} !== {e_cmd, e_cstb, e_data, e_dstb}) begin
                n_fail++;
                $display("FAIL cmd_data_bus i=%0d got cmd=%h/%b data=%h/%b required cmd=%h/%b data=%h/%b",
                         i, CCBCMD, CCBCMDSTRB, CCBDATA, CCBDATASTRB, e_cmd, e_cstb, e_data, e_dstb);
            end
            if (CCBCMDSTRB === 1'b1) t_c = i;
            if (CCBDATASTRB === 1'b1) t_d = i;
        end
        n_tests++;
        if (t_c < 0 || t_d - t_c != 3) begin
            n_fail++; $display("FAIL cmd_data_spacing got cmd_strobe@%0d data_strobe@%0d required spacing 3", t_c, t_d);
        end
        n_tests++;
        if ({CCBCMD, CCBDATA} !== 14'h0) begin
            n_fail++; $display("FAIL cmd_data_idle got cmd=%h data=%h required 0", CCBCMD, CCBDATA);
        end
    endtask

    task automatic test_fifo_full();
        int nstb = 0, last = -1;
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 32; i++) begin
            CMD_WE = (i < 7);
            CMD_IS_DATA = 1'($urandom_range(0, 1));
            CMD_WORD = 8'($urandom);
            tick();
            n_tests++;
            if ({CCBCMD, CCBCMDSTRB, CCBDATA, CCBDATASTRB, CMD_FULL, OVERFLOW} !== {e_cmd, e_cstb, e_data, e_dstb, e_full, m_ovf}) begin
                n_fail++;
                $display("FAIL fifo_full i=%0d got cmd=%h/%b data=%h/%b full=%b ovf=%b required cmd=%h/%b data=%h/%b full=%b ovf=%b",
                         i, CCBCMD, CCBCMDSTRB, CCBDATA, CCBDATASTRB, CMD_FULL, OVERFLOW, e_cmd, e_cstb, e_data, e_dstb, e_full, m_ovf);
            end
            if (CCBCMDSTRB === 1'b1 || CCBDATASTRB === 1'b1) begin
                if (last >= 0) begin
                    n_tests++;
                    if (i - last != 3) begin
                        n_fail++; $display("FAIL fifo_strobe_spacing got %0d required 3", i - last);
                    end
                end
                last = i; nstb++;
            end
        end
        CMD_WE = 1'b0;
        n_tests++;
        if (nstb != 6 || OVERFLOW !== 1'b1) begin
            n_fail++; $display("FAIL fifo_accepted got strobes=%0d ovf=%b required 6 and 1", nstb, OVERFLOW);
        end
    endtask

    task automatic test_random_cmds();
        for (int i = 0; i < 320; i++) begin
            CMD_WE = (i < 300) && ($urandom_range(0, 2) == 0);
            CMD_IS_DATA = 1'($urandom_range(0, 1));
            CMD_WORD = 8'($urandom);
            tick();
            n_tests++;
            if ({CCBCMD, CCBCMDSTRB, CCBDATA, CCBDATASTRB, CMD_FULL, OVERFLOW} !== {e_cmd, e_cstb, e_data, e_dstb, e_full, m_ovf}) begin
                n_fail++;
                $display("FAIL random_cmds i=%0d got cmd=%h/%b data=%h/%b full=%b required cmd=%h/%b data=%h/%b full=%b",
                         i, CCBCMD, CCBCMDSTRB, CCBDATA, CCBDATASTRB, CMD_FULL, e_cmd, e_cstb, e_data, e_dstb, e_full);
            end
        end
        CMD_WE = 1'b0;
    endtask

    task automatic test_orbit();
        int pulses = 0, last = -1;
        ENABLE = 1'b1;
        for (int i = 0; i < 7200; i++) begin
            tick();
            n_tests++;
            if ({BX0, BXN} !== {e_bx0, 12'(m_bxn)}) begin
                n_fail++; $display("FAIL orbit i=%0d got bx0=%b bxn=%0d required bx0=%b bxn=%0d", i, BX0, BXN, e_bx0, m_bxn);
            end
            if (BX0 === 1'b1) begin
                if (last >= 0) begin
                    n_tests++;
                    if (i - last != ORBIT) begin
                        n_fail++; $display("FAIL bx0_spacing got %0d required %0d", i - last, ORBIT);
                    end
                end
                last = i; pulses++;
            end
        end
        n_tests++;
        if (pulses != 3) begin
            n_fail++; $display("FAIL bx0_count got %0d required 3", pulses);
        end
    endtask

    task automatic test_bxrst();
        int guard = 0;
        ENABLE = 1'b1;
        while (m_bxn != ORBIT - 1 && guard < 2 * ORBIT) begin
            tick(); guard++;
        end
        n_tests++;
        if (BXN !== 12'(ORBIT - 1)) begin
            n_fail++; $display("FAIL bxrst_pre got bxn=%0d required %0d", BXN, ORBIT - 1);
        end
        BXRST_REQ = 1'b1; tick(); BXRST_REQ = 1'b0;
        n_tests++;
        if ({BXRST, BX0, BXN} !== {1'b1, 1'b1, 12'd0}) begin
            n_fail++; $display("FAIL bxrst_pulse got bxrst=%b bx0=%b bxn=%0d required 1 1 0", BXRST, BX0, BXN);
        end
        tick();
        n_tests++;
        if ({BXRST, BX0, BXN} !== {1'b0, 1'b0, 12'd1}) begin
            n_fail++; $display("FAIL bxrst_after got bxrst=%b bx0=%b bxn=%0d required 0 0 1", BXRST, BX0, BXN);
        end
    endtask

    task automatic test_l1a();
        int acc_seen = 0;
        for (int i = 0; i < 10; i++) begin
            L1A_REQ = (i % 2 == 0);
            tick();
            n_tests++;
            if ({L1ACC, L1ARST, L1ANUM} !== {e_l1acc, e_l1arst, m_l1a}) begin
                n_fail++; $display("FAIL l1a i=%0d got acc=%b num=%0d required acc=%b num=%0d", i, L1ACC, L1ANUM, e_l1acc, m_l1a);
            end
            if (L1ACC === 1'b1) acc_seen++;
        end
        n_tests++;
        if (L1ANUM !== 24'd5) begin
            n_fail++; $display("FAIL l1a_count got %0d required 5", L1ANUM);
        end
        L1A_REQ = 1'b1; L1ARST_REQ = 1'b1; tick(); L1A_REQ = 1'b0; L1ARST_REQ = 1'b0;
        n_tests++;
        if ({L1ACC, L1ARST, L1ANUM} !== {1'b1, 1'b1, 24'd0}) begin
            n_fail++; $display("FAIL l1a_reset_wins got acc=%b rst=%b num=%0d required 1 1 0", L1ACC, L1ARST, L1ANUM);
        end
        if (L1ACC === 1'b1) acc_seen++;
        tick();
        n_tests++;
        if (acc_seen != 6 || L1ACC !== 1'b0) begin
            n_fail++; $display("FAIL l1a_pulses got %0d acc=%b required 6 0", acc_seen, L1ACC);
        end
    endtask

    task automatic test_cal();
        logic [2:0] exp_tab [6] = '{3'b101, 3'b101, 3'b111, 3'b111, 3'b111, 3'b111};
        logic       seq0 [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       exp0 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        CAL_REQ = 3'b000; tick(); tick();
        for (int i = 0; i < 6; i++) begin
            CAL_REQ = (i < 4) ? 3'b010 : 3'b000;
            tick();
            n_tests++;
            if (CCBCAL !== exp_tab[i] || CCBCAL !== e_cal) begin
                n_fail++; $display("FAIL cal_pulse i=%0d got %b required %b", i, CCBCAL, exp_tab[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            CAL_REQ = {2'b00, seq0[i]};
            tick();
            n_tests++;
            if (CCBCAL[0] !== exp0[i]) begin
                n_fail++; $display("FAIL cal_retrigger i=%0d got %b required %b", i, CCBCAL[0], exp0[i]);
            end
        end
    endtask

    task automatic test_random_misc();
        for (int i = 0; i < 400; i++) begin
            ENABLE = ($urandom_range(0, 7) != 0);
            BXRST_REQ = ($urandom_range(0, 49) == 0);
            L1A_REQ = 1'($urandom_range(0, 1));
            L1ARST_REQ = ($urandom_range(0, 19) == 0);
            CAL_REQ = 3'($urandom);
            tick();
            n_tests++;
            if ({BX0, BXRST, BXN, L1ACC, L1ARST, L1ANUM, CCBCAL} !== {e_bx0, e_bxrst, 12'(m_bxn), e_l1acc, e_l1arst, m_l1a, e_cal}) begin
                n_fail++;
                $display("FAIL random_misc i=%0d got bx0=%b bxrst=%b bxn=%0d acc=%b l1rst=%b num=%0d cal=%b required %b %b %0d %b %b %0d %b",
                         i, BX0, BXRST, BXN, L1ACC, L1ARST, L1ANUM, CCBCAL, e_bx0, e_bxrst, m_bxn, e_l1acc, e_l1arst, m_l1a, e_cal);
            end
        end
        BXRST_REQ = 1'b0; L1A_REQ = 1'b0; L1ARST_REQ = 1'b0; CAL_REQ = 3'b000;
    endtask

    initial begin
        test_reset();
        test_cmd_data();
        test_fifo_full();
        test_random_cmds();
        test_orbit();
        test_bxrst();
        test_l1a();
        test_cal();
        test_random_misc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
